// File: rtl/regbank_write_arbiter_pkg.sv
// rtl/regbank_write_arbiter_pkg.sv - shared types, defaults and helpers for the register-bank write arbiter
package regbank_write_arbiter_pkg;

    // Arbiter FSM: IDLE arbitrates per beat, BURST holds the grant on the locked requester
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam int          DEF_NREQ    = 3;
    localparam int          DEF_DW      = 32;
    localparam int          DEF_AW      = 5;
    localparam logic [4:0]  DEF_PC_ADDR = 5'h0F;

    // Round-robin successor of a requester index
    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_pick.sv
// rtl/regbank_write_arbiter_rr_pick.sv - NREQ-wide round-robin picker (request vector + pointer -> one-hot grant and index)
module rr_pick
    import regbank_write_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW-1:0] cand;

    // Scan ptr, ptr+1, ... wrapping at NREQ; the first requesting slot wins
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = ptr_i;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_o && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                any_o         = 1'b1;
            end
            cand = IW'(next_idx(int'(cand), NREQ));
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// rtl/regbank_write_arbiter.sv - round-robin writeback arbiter onto registerbank write/PC ports; optional same-cycle bypass under REGARB_BYPASS_EN
module regbank_write_arbiter
    import regbank_write_arbiter_pkg::*;
#(
    parameter int             NREQ    = DEF_NREQ,
    parameter int             DW      = DEF_DW,
    parameter int             AW      = DEF_AW,
    parameter logic [AW-1:0]  PC_ADDR = AW'(DEF_PC_ADDR)
) (
    input  logic               clk1,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_last,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [DW-1:0]      rb_write,
    output logic [AW-1:0]      rb_addr,
    output logic               rb_w,
    output logic [DW-1:0]      rb_pc_write,
    output logic               rb_pc_w,
`ifdef REGARB_BYPASS_EN
    input  logic [AW-1:0]      byp_raddr,
    output logic               byp_hit,
    output logic [DW-1:0]      byp_data,
`endif
    output logic               busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  lock_q, lock_d;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    logic [NREQ-1:0] ready_c;
    logic [IW-1:0]   sel_idx;
    logic            xfer;
    logic            sel_last;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            sel_is_pc;

    logic            rb_w_q, rb_w_d;
    logic            rb_pc_w_q, rb_pc_w_d;
    logic [AW-1:0]   rb_addr_q, rb_addr_d;
    logic [DW-1:0]   rb_write_q, rb_write_d;
    logic [DW-1:0]   rb_pc_write_q, rb_pc_write_d;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Grant selection: free arbitration in IDLE, locked requester only in BURST
    always_comb begin
        ready_c = '0;
        sel_idx = pick_idx;
        if (state_q == ST_BURST) begin
            ready_c[lock_q] = 1'b1;
            sel_idx         = lock_q;
        end else begin
            ready_c = pick_grant;
        end
    end

    // Ready is forced low while reset is held so nothing can handshake during reset
    assign req_ready = rst_n ? ready_c : '0;

    assign xfer      = |(req_valid & req_ready);
    assign sel_last  = req_last[sel_idx];
    assign sel_addr  = req_addr[int'(sel_idx) * AW +: AW];
    assign sel_data  = req_data[int'(sel_idx) * DW +: DW];
    assign sel_is_pc = (sel_addr == PC_ADDR);

    // FSM next state and round-robin pointer / lock update on each transferred beat
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        if (xfer) begin
            if (state_q == ST_IDLE) begin
                if (sel_last) begin
                    ptr_d = IW'(next_idx(int'(sel_idx), NREQ));
                end else begin
                    state_d = ST_BURST;
                    lock_d  = sel_idx;
                end
            end else if (sel_last) begin
                state_d = ST_IDLE;
                ptr_d   = IW'(next_idx(int'(lock_q), NREQ));
            end
        end
    end

    // Registerbank port next values: one-cycle strobes, data/addr hold between strobes
    always_comb begin
        rb_w_d        = 1'b0;
        rb_pc_w_d     = 1'b0;
        rb_addr_d     = rb_addr_q;
        rb_write_d    = rb_write_q;
        rb_pc_write_d = rb_pc_write_q;
        if (xfer) begin
            if (sel_is_pc) begin
                rb_pc_w_d     = 1'b1;
                rb_pc_write_d = sel_data;
            end else begin
                rb_w_d     = 1'b1;
                rb_addr_d  = sel_addr;
                rb_write_d = sel_data;
            end
        end
    end

    // State, pointer and output registers; reset abandons any burst and pending strobe
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            lock_q        <= '0;
            rb_w_q        <= 1'b0;
            rb_pc_w_q     <= 1'b0;
            rb_addr_q     <= '0;
            rb_write_q    <= '0;
            rb_pc_write_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            lock_q        <= lock_d;
            rb_w_q        <= rb_w_d;
            rb_pc_w_q     <= rb_pc_w_d;
            rb_addr_q     <= rb_addr_d;
            rb_write_q    <= rb_write_d;
            rb_pc_write_q <= rb_pc_write_d;
        end
    end

    assign rb_w        = rb_w_q;
    assign rb_pc_w     = rb_pc_w_q;
    assign rb_addr     = rb_addr_q;
    assign rb_write    = rb_write_q;
    assign rb_pc_write = rb_pc_write_q;
    assign busy        = (state_q == ST_BURST);

`ifdef REGARB_BYPASS_EN
    logic gp_hit;
    logic pc_hit;

    // Same-cycle forwarding of the write currently strobing into the registerbank
    always_comb begin
        gp_hit   = rb_w_q && (rb_addr_q == byp_raddr);
        pc_hit   = rb_pc_w_q && (byp_raddr == PC_ADDR);
        byp_hit  = gp_hit || pc_hit;
        byp_data = '0;
        if (gp_hit) begin
            byp_data = rb_write_q;
        end else if (pc_hit) begin
            byp_data = rb_pc_write_q;
        end
    end
`endif

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb/tb_regbank_write_arbiter.sv - scoreboard testbench for regbank_write_arbiter (bypass checks when REGARB_BYPASS_EN is defined)
module tb_regbank_write_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam logic [AW-1:0] PCA = 5'h0F;

    logic               clk1;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_last;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [DW-1:0]      rb_write;
    logic [AW-1:0]      rb_addr;
    logic               rb_w;
    logic [DW-1:0]      rb_pc_write;
    logic               rb_pc_w;
    logic               busy;
    logic [AW-1:0]      byp_raddr;
`ifdef REGARB_BYPASS_EN
    logic               byp_hit;
    logic [DW-1:0]      byp_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic          w;
        logic          pc_w;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    bit            m_burst;
    int            m_ptr;
    int            m_lock;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_write;
    logic [DW-1:0] m_pc_write;

    exp_t            e_out;
    exp_t            e_new;
    logic [NREQ-1:0] m_ready;
    int              m_sel;
    int              m_idx;

    regbank_write_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .AW      (AW),
        .PC_ADDR (PCA)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rb_write    (rb_write),
        .rb_addr     (rb_addr),
        .rb_w        (rb_w),
        .rb_pc_write (rb_pc_write),
        .rb_pc_w     (rb_pc_w),
`ifdef REGARB_BYPASS_EN
        .byp_raddr   (byp_raddr),
        .byp_hit     (byp_hit),
        .byp_data    (byp_data),
`endif
        .busy        (busy)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic l,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_last[i]           = l;
        req_addr[i*AW +: AW]  = a;
        req_data[i*DW +: DW]  = d;
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic cyc();
        @(posedge clk1);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rb_w"},        64'(rb_w),        64'd0);
        check({tag, "_rb_pc_w"},     64'(rb_pc_w),     64'd0);
        check({tag, "_rb_addr"},     64'(rb_addr),     64'd0);
        check({tag, "_rb_write"},    64'(rb_write),    64'd0);
        check({tag, "_rb_pc_write"}, 64'(rb_pc_write), 64'd0);
        check({tag, "_req_ready"},   64'(req_ready),   64'd0);
        check({tag, "_busy"},        64'(busy),        64'd0);
    endtask

    // Monitor: compare registerbank outputs with the entry scheduled last cycle,
    // then model this cycle's arbitration and schedule its expected output
    always @(negedge clk1) begin
        if (!rst_n) begin
            sb.delete();
            m_burst    = 1'b0;
            m_ptr      = 0;
            m_lock     = 0;
            m_addr     = '0;
            m_write    = '0;
            m_pc_write = '0;
        end else begin
            if (sb.size() > 0) e_out = sb.pop_front();
            else e_out = '{w: 1'b0, pc_w: 1'b0, addr: '0, data: '0};
            if (e_out.w) begin
                m_addr  = e_out.addr;
                m_write = e_out.data;
            end
            if (e_out.pc_w) m_pc_write = e_out.data;
            check("rb_w",        64'(rb_w),        64'(e_out.w));
            check("rb_pc_w",     64'(rb_pc_w),     64'(e_out.pc_w));
            check("rb_addr",     64'(rb_addr),     64'(m_addr));
            check("rb_write",    64'(rb_write),    64'(m_write));
            check("rb_pc_write", 64'(rb_pc_write), 64'(m_pc_write));
`ifdef REGARB_BYPASS_EN
            begin
                logic exp_hit;
                exp_hit = (e_out.w && e_out.addr == byp_raddr) || (e_out.pc_w && byp_raddr == PCA);
                check("byp_hit", 64'(byp_hit), 64'(exp_hit));
                if (exp_hit) check("byp_data", 64'(byp_data), 64'(e_out.data));
            end
`endif
            m_ready = '0;
            m_sel   = -1;
            if (m_burst) begin
                m_sel = m_lock;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    m_idx = (m_ptr + k) % NREQ;
                    if (m_sel < 0 && req_valid[m_idx]) m_sel = m_idx;
                end
            end
            if (m_sel >= 0) m_ready[m_sel] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(m_ready));
            check("busy",      64'(busy),      64'(m_burst));

            e_new = '{w: 1'b0, pc_w: 1'b0, addr: '0, data: '0};
            if (m_sel >= 0 && req_valid[m_sel]) begin
                e_new.addr = req_addr[m_sel*AW +: AW];
                e_new.data = req_data[m_sel*DW +: DW];
                e_new.pc_w = (e_new.addr == PCA);
                e_new.w    = !e_new.pc_w;
                if (req_last[m_sel]) begin
                    m_burst = 1'b0;
                    m_ptr   = (m_sel + 1) % NREQ;
                end else begin
                    m_burst = 1'b1;
                    m_lock  = m_sel;
                end
            end
            sb.push_back(e_new);
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_addr  = '0;
        req_data  = '0;
        byp_raddr = '0;
        repeat (2) cyc();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cyc();

        // Single beat from requester 0
        set_req(0, 1'b1, 1'b1, 5'h01, 32'hFFFF_FFFF);
        byp_raddr = 5'h01;
        cyc();
        clear_all();
        repeat (2) cyc();

        // Requester 1 burst 04/05/06 with 0 and 2 contending; valid drops once mid-burst
        set_req(0, 1'b1, 1'b1, 5'h02, 32'h0000_0002);
        set_req(2, 1'b1, 1'b1, 5'h03, 32'h0000_0003);
        set_req(1, 1'b1, 1'b0, 5'h04, 32'h1111_0004);
        cyc();
        set_req(1, 1'b0, 1'b0, 5'h05, 32'h1111_0005);
        cyc();
        set_req(1, 1'b1, 1'b0, 5'h05, 32'h1111_0005);
        cyc();
        set_req(1, 1'b1, 1'b1, 5'h06, 32'h1111_0006);
        cyc();
        set_req(1, 1'b0, 1'b0, 5'h00, 32'h0);
        repeat (2) cyc();
        clear_all();
        cyc();

        // PC routing
        set_req(2, 1'b1, 1'b1, 5'h0F, 32'h0000_0100);
        byp_raddr = 5'h0F;
        cyc();
        clear_all();
        repeat (2) cyc();

        // Bypass pattern: hit on 07, then a miss with raddr 08
        set_req(0, 1'b1, 1'b1, 5'h07, 32'hA5A5_A5A5);
        byp_raddr = 5'h07;
        cyc();
        clear_all();
        cyc();
        set_req(0, 1'b1, 1'b1, 5'h07, 32'hA5A5_A5A5);
        byp_raddr = 5'h08;
        cyc();
        clear_all();
        repeat (2) cyc();

        // All requesters valid every cycle with single beats, including high addresses
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, 1'b1, 1'b1, AW'(16 + ((c * NREQ + i) % 16)), $urandom);
            cyc();
        end
        clear_all();
        cyc();

        // Random valids/lasts/addresses including PC address
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                        ($urandom_range(0, 5) == 0) ? PCA : AW'($urandom), $urandom);
            byp_raddr = ($urandom_range(0, 1) == 1) ? req_addr[0 +: AW] : AW'($urandom);
            cyc();
        end
        clear_all();
        for (int c = 0; c < 8; c++) begin
            req_last = '1;
            cyc();
        end
        clear_all();
        cyc();

        // Reset asserted mid-cycle right after a burst beat transferred
        set_req(1, 1'b1, 1'b0, 5'h0A, 32'hDEAD_0001);
        cyc();
        @(posedge clk1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b1, 1'b1, AW'(8 + i), 32'hC0DE_0000 + i);
        cyc();
        rst_n = 1'b1;
        repeat (4) cyc();
        clear_all();
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
